multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle MIPS datapath: one shared memory port, one ALU, plus IR, A/B, ALUOut and MDR holding registers.
- Sequences the FETCH/DECODE/execute steps for R-type, lw, sw, beq and j, and drives every datapath select and write-enable each cycle.
- Waits on the memory ready handshake, counts retired instructions and halts on an illegal opcode.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  level; allow fetching of new instructions
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
ir_write  output  1  load IR from memory data
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct decode
reg_dest  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
state  output  4  current state encoding (debug)
halted  output  1  in TRAP
instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (reset_n=0, async): state=IDLE, instr_count=0. Every output is 0 while in IDLE. reset_n low mid-instruction aborts immediately with no further writes.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, TRAP=11. Values 12-15 go to IDLE.
- Outputs are decoded from the state. Any output not listed for a state is 0.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are Mealy outputs, equal to mem_ready.
  - Stay in FETCH while mem_ready=0. Go to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dest=0, mem_to_reg=1, reg_write=1. Instruction completes.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready. The instruction completes on the mem_ready cycle.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_dest=1, mem_to_reg=0, reg_write=1. Instruction completes.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Instruction completes.
- JUMP: pc_write=1, pc_source=10. Instruction completes.
- On completion:
  - instr_count increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - Dropping run never aborts an instruction already in flight.
- TRAP: halted=1 and all other outputs 0. Stays in TRAP until reset; run is ignored. instr_count does not increment.
- mem_read and mem_write are never both 1. reg_write, pc_write and ir_write are never asserted in the same cycle as mem_write.
- Latency with mem_ready held at 1:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=000000 -> states 1,2,7,8,1. reg_write=1 only in state 8 with reg_dest=1. instr_count=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD -> states 1,2,3,4,4,4,5. MEM_RD shows mem_read=1, i_or_d=1. MEM_WB shows mem_to_reg=1, reg_write=1. instr_count+1.
- sw (101011) with mem_ready=0 for 3 cycles in FETCH -> ir_write=pc_write=0 until the mem_ready cycle. MEM_WR shows mem_write=1, reg_write=0. Returns to FETCH.
- beq (000100) then j (000010) -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01. JUMP shows pc_write=1, pc_source=10. instr_count increases by 2.
- Illegal opcode 111111 -> DECODE goes to TRAP. halted=1 and stays 1 with run toggling. Asserting reset_n=0 returns to IDLE with instr_count=0.
- Mid-instruction events:
  - run deasserted during EXECUTE -> ALU_WB completes, then IDLE.
  - reset_n pulsed low asynchronously in MEM_RD -> immediately IDLE, all outputs 0.
  - With CNT_W=4, 16 retired instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multi-cycle MIPS datapath,
// sequencing fetch/decode/execute and driving every datapath select and enable.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dest,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXECUTE  = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  state_t cur, nxt;
  logic done;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= IDLE;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (done) instr_count <= instr_count + CNT_W'(1);
    end
  end
  always_comb begin
    nxt           = cur;
    done          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dest      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    case (cur)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        nxt = opcode == OP_R                     ? EXECUTE  :
              (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
              opcode == OP_BEQ                   ? BRANCH   :
              opcode == OP_J                     ? JUMP     : TRAP;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = opcode == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nxt      = mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        done      = mem_ready;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = ALU_WB;
      end
      ALU_WB: begin
        reg_dest  = 1'b1;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
      end
      TRAP: halted = 1'b1;
      default: nxt = IDLE;
    endcase
    // a retiring instruction always finishes; run only decides whether to fetch again
    if (done) nxt = run ? FETCH : IDLE;
  end
  assign state = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream with memory stalls, run toggling
// and async resets; a plan-queue reference model feeds a per-cycle scoreboard.
module tb_multicycle_controller;
  localparam int CW = 4;
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_RD = 4,
                 S_MEM_WB = 5, S_MEM_WR = 6, S_EXECUTE = 7, S_ALU_WB = 8, S_BRANCH = 9,
                 S_JUMP = 10, S_TRAP = 11;
  typedef struct packed {
    logic [3:0]    st;
    logic [CW-1:0] cnt;
    logic [15:0]   ctl;
  } rec_t;
  bit clk = 0;
  logic reset_n = 0, run = 0, mem_ready = 0;
  logic [5:0] opcode = '0;
  logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic alu_src_a, reg_dest, mem_to_reg, reg_write, halted;
  logic [3:0] state;
  logic [CW-1:0] instr_count;
  rec_t q[$];
  int plan[$];
  int cur = S_IDLE;
  int trap_n = 0;
  logic [CW-1:0] cnt = '0;
  bit started = 0;
  int asserts = 0, fails = 0;
  always #5 clk = ~clk;
  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state), .halted(halted),
    .instr_count(instr_count)
  );
  function automatic logic [15:0] ctl_of(int s, logic rdy);
    logic mr, mw, iod, irw, pcw, pcc, asa, rd, m2r, rw, h;
    logic [1:0] ps, asb, aop;
    {mr, mw, iod, irw, pcw, pcc, asa, rd, m2r, rw, h} = '0;
    {ps, asb, aop} = '0;
    case (s)
      S_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   asb = 2'b11;
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iod = 1; end
      S_MEM_WB:   begin m2r = 1; rw = 1; end
      S_MEM_WR:   begin mw = 1; iod = 1; end
      S_EXECUTE:  begin asa = 1; aop = 2'b10; end
      S_ALU_WB:   begin rd = 1; rw = 1; end
      S_BRANCH:   begin asa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; end
      S_JUMP:     begin pcw = 1; ps = 2'b10; end
      S_TRAP:     h = 1;
      default:    h = 0;
    endcase
    return {mr, mw, iod, irw, pcw, pcc, ps, asa, asb, aop, rd, m2r, rw, h};
  endfunction
  function automatic logic [5:0] pick_op();
    int r = $urandom_range(0, 99);
    logic [5:0] op;
    if (r < 25) return 6'b000000;
    if (r < 45) return 6'b100011;
    if (r < 65) return 6'b101011;
    if (r < 80) return 6'b000100;
    if (r < 95) return 6'b000010;
    do op = 6'($urandom_range(0, 63));
    while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010);
    return op;
  endfunction
  task automatic push(int s, logic [CW-1:0] c, logic [15:0] ctl);
    rec_t r;
    r.st = 4'(s);
    r.cnt = c;
    r.ctl = ctl;
    q.push_back(r);
  endtask
  // instruction = fixed list of steps after DECODE; memory steps wait on mem_ready
  task automatic advance();
    bit stall;
    stall = (cur == S_FETCH || cur == S_MEM_RD || cur == S_MEM_WR) && !mem_ready;
    if (cur == S_IDLE) cur = run ? S_FETCH : S_IDLE;
    else if (cur == S_TRAP) trap_n++;
    else if (!stall) begin
      if (cur == S_FETCH) cur = S_DECODE;
      else begin
        if (cur == S_DECODE)
          case (opcode)
            6'b000000: plan = '{S_EXECUTE, S_ALU_WB};
            6'b100011: plan = '{S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
            6'b101011: plan = '{S_MEM_ADDR, S_MEM_WR};
            6'b000100: plan = '{S_BRANCH};
            6'b000010: plan = '{S_JUMP};
            default:   plan = '{S_TRAP};
          endcase
        if (plan.size() > 0) cur = plan.pop_front();
        else begin
          cnt = cnt + 1'b1;
          cur = run ? S_FETCH : S_IDLE;
        end
      end
    end
  endtask
  initial begin
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 2 || trap_n >= 4 || (cur == S_MEM_RD && $urandom_range(0, 9) == 0) ||
          $urandom_range(0, 299) == 0) begin
        reset_n = 0;
        cur = S_IDLE;
        plan.delete();
        cnt = '0;
        trap_n = 0;
        push(S_IDLE, cnt, 16'h0);
      end else begin
        reset_n = 1;
        run = $urandom_range(0, 99) < 90;
        mem_ready = $urandom_range(0, 99) < 70;
        if (cur == S_FETCH || cur == S_IDLE) opcode = pick_op();
        push(cur, cnt, ctl_of(cur, mem_ready));
        advance();
      end
      started = 1;
    end
    @(negedge clk);
    #2;
    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
  initial begin
    rec_t e, got;
    wait (started);
    forever begin
      @(negedge clk);
      got.st = state;
      got.cnt = instr_count;
      got.ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                 alu_src_a, alu_src_b, alu_op, reg_dest, mem_to_reg, reg_write, halted};
      asserts++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL underflow at %0t: DUT state %0d with no expectation", $time, state);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL cycle @%0t: got state=%0d cnt=%0d ctl=%h, required state=%0d cnt=%0d ctl=%h",
                   $time, got.st, got.cnt, got.ctl, e.st, e.cnt, e.ctl);
        end
      end
      asserts++;
      if ((mem_read && mem_write) || (mem_write && (reg_write || pc_write || ir_write))) begin
        fails++;
        $display("FAIL exclusivity @%0t: mem_read=%b mem_write=%b reg_write=%b pc_write=%b ir_write=%b",
                 $time, mem_read, mem_write, reg_write, pc_write, ir_write);
      end
    end
  end
endmodule
